// File: rtl/demux1to4_stream.sv
// ---------------------------------------------------------------------------
// demux1to4_stream
//   1-to-4 valid/ready stream demultiplexer. Each input word is steered to one
//   of four output channels. The destination is either the explicit in_sel or
//   an internal round-robin pointer. Every channel owns a one-entry holding
//   register, so a stalled consumer back-pressures only words addressed to it.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake (in_ready is the only comb output)
//   in_data [wd-1:0]      input word
//   in_sel  [1:0]         destination when rr_en=0
//   rr_en                 1 = round-robin destination, 0 = in_sel
//   out_valid[3:0]        per-channel word-present flags
//   out_ready[3:0]        per-channel consumer ready
//   out_data0..3          channel holding registers
//   acc_cnt [7:0]         accepted-word counter, wraps 255 -> 0
//   rr_ptr  [1:0]         current round-robin pointer
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// demux1to4_stream_chan
//   One output channel: a single-entry holding register with valid flag.
//   A load and a pop in the same cycle keep valid high and replace the data,
//   giving one word per clock of throughput per channel.
//
// Ports
//   clk, rst_n   clock / async active-low reset
//   load         write din this edge (caller guarantees room or pop)
//   din          word to hold
//   ready        consumer ready
//   valid        word present
//   data         held word
// ---------------------------------------------------------------------------
module demux1to4_stream_chan #(
   parameter int wd = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [wd-1:0] din,
   input  logic          ready,
   output logic          valid,
   output logic [wd-1:0] data
);

   logic pop;

   assign pop = valid & ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
      end else begin
         if (load) begin
            valid <= 1'b1;
            data  <= din;
         end else if (pop) begin
            // data is left as-is; it is don't-care once valid drops
            valid <= 1'b0;
         end
      end
   end

endmodule

module demux1to4_stream #(
   parameter int wd = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [wd-1:0] in_data,
   input  logic [1:0]    in_sel,
   input  logic          rr_en,
   output logic [3:0]    out_valid,
   input  logic [3:0]    out_ready,
   output logic [wd-1:0] out_data0,
   output logic [wd-1:0] out_data1,
   output logic [wd-1:0] out_data2,
   output logic [wd-1:0] out_data3,
   output logic [7:0]    acc_cnt,
   output logic [1:0]    rr_ptr
);

   localparam int NUM_CH = 4;

   logic [1:0]                  dest;
   logic                        accept;
   logic [NUM_CH-1:0]           load;
   logic [NUM_CH-1:0][wd-1:0]   ch_data;

   // Destination is chosen from the current pointer/select, never from
   // in_valid, so in_ready has no path back from the handshake.
   assign dest     = rr_en ? rr_ptr : in_sel;
   assign in_ready = ~out_valid[dest] | out_ready[dest];
   assign accept   = in_valid & in_ready;

   always_comb begin
      load       = '0;
      load[dest] = accept;
   end

   genvar k;
   generate
      for (k = 0; k < NUM_CH; k++) begin : g_ch
         demux1to4_stream_chan #(.wd(wd)) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[k]),
            .din   (in_data),
            .ready (out_ready[k]),
            .valid (out_valid[k]),
            .data  (ch_data[k])
         );
      end
   endgenerate

   assign out_data0 = ch_data[0];
   assign out_data1 = ch_data[1];
   assign out_data2 = ch_data[2];
   assign out_data3 = ch_data[3];

   // Pointer advances only on an accepted round-robin word; a stalled
   // channel therefore holds the whole stream (strict order, no skipping).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr  <= 2'd0;
         acc_cnt <= 8'd0;
      end else if (accept) begin
         acc_cnt <= acc_cnt + 8'd1;
         if (rr_en)
            rr_ptr <= rr_ptr + 2'd1;
      end
   end

endmodule

// File: tb/tb_demux1to4_stream.sv
module tb_demux1to4_stream;

   localparam int wd = 4;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [wd-1:0] in_data;
   logic [1:0]    in_sel;
   logic          rr_en;
   logic [3:0]    out_valid;
   logic [3:0]    out_ready;
   logic [wd-1:0] out_data0, out_data1, out_data2, out_data3;
   logic [7:0]    acc_cnt;
   logic [1:0]    rr_ptr;

   demux1to4_stream #(.wd(wd)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .rr_en     (rr_en),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data0 (out_data0),
      .out_data1 (out_data1),
      .out_data2 (out_data2),
      .out_data3 (out_data3),
      .acc_cnt   (acc_cnt),
      .rr_ptr    (rr_ptr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // scoreboard: expected words per channel, plus reference state
   logic [wd-1:0] q [4][$];
   logic [3:0]    mv;
   logic [1:0]    m_ptr;
   logic [7:0]    m_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [wd-1:0] dout(input int k);
      case (k)
         0: return out_data0;
         1: return out_data1;
         2: return out_data2;
         default: return out_data3;
      endcase
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 4; k++) q[k].delete();
      mv = 4'b0; m_ptr = 2'd0; m_cnt = 8'd0;
   endtask

   // Called at posedge+1 with inputs already driven. Checks comb/held state
   // mid-cycle, advances the model, then checks registered outputs after the edge.
   task automatic tick();
      logic [1:0] d;
      logic       ir, acc;
      logic [3:0] pop, ld;
      #3;
      d  = rr_en ? m_ptr : in_sel;
      ir = ~mv[d] | out_ready[d];
      check("in_ready", in_ready, ir);
      for (int k = 0; k < 4; k++)
         if (mv[k]) check($sformatf("out_data%0d", k), dout(k), q[k][0]);
      acc = in_valid & ir;
      pop = mv & out_ready;
      for (int k = 0; k < 4; k++)
         if (pop[k]) void'(q[k].pop_front());
      ld = 4'b0;
      if (acc) begin
         ld[d] = 1'b1;
         q[d].push_back(in_data);
         m_cnt = m_cnt + 8'd1;
         if (rr_en) m_ptr = m_ptr + 2'd1;
      end
      mv = (mv & ~pop) | ld;
      @(posedge clk); #1;
      check("out_valid", out_valid, mv);
      check("acc_cnt", acc_cnt, m_cnt);
      check("rr_ptr", rr_ptr, m_ptr);
   endtask

   // Asynchronous reset pulse starting at posedge+1; outputs checked before any edge.
   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      check("rst out_valid", out_valid, 4'b0);
      check("rst out_data0", out_data0, 0);
      check("rst out_data1", out_data1, 0);
      check("rst out_data2", out_data2, 0);
      check("rst out_data3", out_data3, 0);
      check("rst acc_cnt", acc_cnt, 0);
      check("rst rr_ptr", rr_ptr, 0);
      check("rst in_ready", in_ready, 1'b1);
      rst_n = 1'b1;
      model_reset();
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [1:0] sel, input logic [wd-1:0] data);
      in_valid = 1'b1; in_sel = sel; in_data = data;
      tick();
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst_n = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = 2'd0;
      rr_en = 1'b0; out_ready = 4'b0000;
      model_reset();
      @(posedge clk); #1;
      do_reset();

      // explicit select, all ready: one word per clock
      out_ready = 4'b1111;
      send(2'd0, 4'd1);
      send(2'd1, 4'd3);
      send(2'd2, 4'd7);
      send(2'd3, 4'd15);
      idle(2);
      check("acc_cnt after 4", acc_cnt, 8'd4);

      // back-pressure on channel 2, then simultaneous pop+load
      out_ready = 4'b0000;
      send(2'd2, 4'd7);
      check("ch2 holds 7", out_data2, 4'd7);
      send(2'd2, 4'd9);
      send(2'd2, 4'd9);
      out_ready = 4'b0100;
      send(2'd2, 4'd9);
      check("ch2 replaced", out_data2, 4'd9);
      check("ch2 still valid", out_valid[2], 1'b1);
      out_ready = 4'b1111;
      idle(2);

      // round robin: channels 0,1,2,3,0,1
      rr_en = 1'b1;
      for (int i = 1; i <= 6; i++) send(2'd3, 4'(i));
      check("rr_ptr end", rr_ptr, 2'd2);
      idle(1);

      // strict-order stall on channel 1
      out_ready = 4'b1101;
      for (int i = 0; i < 3; i++) send(2'd0, 4'(8 + i));
      rr_en = 1'b0;
      send(2'd1, 4'hA);
      rr_en = 1'b1;
      for (int i = 0; i < 3; i++) send(2'd2, 4'hB);
      check("stalled in_ready", in_ready, 1'b0);
      out_ready = 4'b1111;
      send(2'd2, 4'hB);
      send(2'd0, 4'hC);
      idle(2);

      // random phase: mixed modes and ready patterns
      for (int i = 0; i < 60; i++) begin
         rr_en     = 1'($urandom_range(0, 1));
         out_ready = 4'($urandom);
         in_valid  = 1'($urandom_range(0, 3) != 0);
         in_sel    = 2'($urandom);
         in_data   = 4'($urandom);
         tick();
      end
      out_ready = 4'b1111;
      idle(2);

      // counter wrap: 256 accepts from reset reads 0
      do_reset();
      out_ready = 4'b1111;
      rr_en = 1'b0;
      for (int i = 0; i < 256; i++) send(2'($urandom), 4'($urandom));
      check("acc_cnt wrap", acc_cnt, 8'd0);
      idle(1);

      // async reset with channels 0 and 3 held and rr_ptr=3
      out_ready = 4'b0110;
      rr_en = 1'b1;
      for (int i = 0; i < 3; i++) send(2'd0, 4'(4 + i));
      rr_en = 1'b0;
      send(2'd3, 4'h5);
      in_valid = 1'b0;
      check("pre-rst out_valid", out_valid, 4'b1001);
      check("pre-rst rr_ptr", rr_ptr, 2'd3);
      do_reset();
      out_ready = 4'b1111;
      send(2'd1, 4'h6);
      idle(1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/demux1to4_stream.md
Name: demux1to4_stream

Overview:
- 1-to-4 stream demultiplexer; the distribution-side counterpart of the 4-to-1 data mux.
- Accepts words on a single valid/ready input stream and steers each word to one of four output channels.
- Destination comes from an explicit select or from an internal round-robin pointer.
- Each output channel has a one-entry holding register, so a stalled consumer back-pressures only words addressed to it.

Parameters:
- wd, 4, data width in bits of the input and of each output channel.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  input word present
- in_ready  output  1  block can accept the input word this cycle
- in_data  input  wd  input word
- in_sel  input  2  destination channel when rr_en=0
- rr_en  input  1  1 = round-robin destination, 0 = use in_sel
- out_valid  output  4  per-channel word-present flags, bit k = channel k
- out_ready  input  4  per-channel consumer ready, bit k = channel k
- out_data0, out_data1, out_data2, out_data3  output  wd each  channel holding registers
- acc_cnt  output  8  count of accepted input words
- rr_ptr  output  2  current round-robin pointer

Behaviour:
- Reset (rst_n=0, asynchronous, overrides all): out_valid=4'b0000, out_data0..3=0, acc_cnt=0, rr_ptr=0. in_ready=1 whenever no channel is full.
- Reset asserted mid-transfer: held words are discarded, with no partial output. Normal operation resumes on the first rising edge after deassertion.
- dest = rr_en ? rr_ptr : in_sel. This is combinational and sampled in the same cycle as in_valid.
- in_ready = ~out_valid[dest] | out_ready[dest]. This is combinational, with no dependency on in_valid, so there is no combinational loop.
- accept = in_valid & in_ready.
- On accept at edge t:
  - out_data<dest> <= in_data.
  - out_valid[dest] = 1 from t.
  - Latency is one clock.
- Per channel k, each edge:
  - load_k & pop_k (simultaneous): valid stays 1 and data is replaced. Full throughput is 1 word/clk per channel.
  - load_k only: valid <= 1.
  - pop_k (out_valid[k] & out_ready[k]) only: valid <= 0. Data register holds its old value and is don't-care.
  - neither: hold.
- Stability: while out_valid[k]=1 and out_ready[k]=0, out_data<k> and out_valid[k] must not change.
- in_valid without in_ready: no state change. The source holds in_data and in_sel or may change them. The block does not require source stability.
- rr_ptr:
  - Increments mod 4 on each accept when rr_en=1, so 3 wraps to 0.
  - Holds when rr_en=0 or when there is no accept.
  - Toggling rr_en does not reset the pointer.
  - in_sel is ignored when rr_en=1.
- acc_cnt increments by 1 on each accept in either mode and wraps 255 -> 0. It is not saturating.
- Channels are independent. A full, stalled channel k blocks only words whose dest=k. With rr_en=1 this stalls the whole stream until channel k drains; this is strict-order round-robin with no skip.
- All outputs are registered except in_ready.

Test Plan:
- Reset, then in_sel=0..3 with in_data=1,3,7,15, in_valid=1, all out_ready=1 -> one word per clock; out_data0..3=1,3,7,15; each out_valid bit pulses for exactly one cycle, one clock after its accept; acc_cnt=4.
- out_ready=4'b0000, in_sel=2, send 7 then 9 -> first word accepted, out_data2=7, out_valid[2]=1; in_ready=0 for the second word. Raise out_ready[2] -> 9 is accepted in the same cycle 7 pops, and out_valid[2] stays 1 with out_data2=9.
- rr_en=1, all ready, 6 words 1..6 -> channels 0,1,2,3,0,1 receive 1,2,3,4,5,6; rr_ptr=2 at end.
- rr_en=1, out_ready[1]=0, rr_ptr=1, channel 1 already full -> in_ready=0 and the stream stalls. Other channels are unaffected and drain. After out_ready[1]=1, the stream resumes.
- Send 256 words with all ready -> acc_cnt reads 0 after the 256th accept.
- Reset pulse with channels 0 and 3 holding data and rr_ptr=3 -> out_valid=0, outputs=0, rr_ptr=0 immediately, without waiting for a clock edge.
